// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcodes, ALU control codes and FSM states for the multi-cycle controller
package multicycle_pkg;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED} state_t;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: opcode to instruction class plus the EXEC-stage ALU controls
module ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_rtype,
  output logic       o_addi,
  output logic       o_lw,
  output logic       o_sw,
  output logic       o_beq,
  output logic       o_halt,
  output logic       o_illegal,
  output logic       o_alu_src,
  output logic [2:0] o_alu_ctrl
);
  // R-type opcodes are exactly the ALU codes they request
  assign o_rtype    = !i_op[3] && (i_op[2:0] inside {ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_SUB, ALU_SLT});
  assign o_addi     = i_op == OP_ADDI;
  assign o_lw       = i_op == OP_LW;
  assign o_sw       = i_op == OP_SW;
  assign o_beq      = i_op == OP_BEQ;
  assign o_halt     = i_op == OP_HALT;
  assign o_illegal  = !(o_rtype || o_addi || o_lw || o_sw || o_beq || o_halt);
  assign o_alu_src  = o_addi || o_lw || o_sw;
  assign o_alu_ctrl = o_rtype ? i_op[2:0] : o_beq ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: PC/IR owner sequencing each instruction through FETCH, DECODE, EXEC, MEM and WB
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int              PC_W   = 5,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instr,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            en_im,
  output logic [15:0]     imm,
  output logic [3:0]      rn1,
  output logic [3:0]      rn2,
  output logic [3:0]      wn,
  output logic            alu_src,
  output logic [2:0]      alu_ctrl,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            en_rw,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);
  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            w_rtype, w_addi, w_lw, w_sw, w_beq, w_halt, w_illegal, w_alu_src, w_alu;
  logic [2:0]      w_alu_ctrl;
  ctrl_decode u_dec (
    .i_op      (r_ir[31:28]),
    .o_rtype   (w_rtype),
    .o_addi    (w_addi),
    .o_lw      (w_lw),
    .o_sw      (w_sw),
    .o_beq     (w_beq),
    .o_halt    (w_halt),
    .o_illegal (w_illegal),
    .o_alu_src (w_alu_src),
    .o_alu_ctrl(w_alu_ctrl)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RST_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_ir <= instr;
        r_pc <= r_pc + PC_W'(4);
      end else if (r_state == S_EXEC && w_beq && zero)
        r_pc <= r_pc + PC_W'({r_ir[15:0], 2'b00});
    end
  end
  // Outputs depend only on registered state and IR so they are stable at negedge
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_halt ? S_HALTED : w_illegal ? S_FETCH : S_EXEC;
      S_EXEC:   w_next = (w_lw || w_sw) ? S_MEM : (w_rtype || w_addi) ? S_WB : S_FETCH;
      S_MEM:    w_next = w_lw ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
    w_alu      = r_state inside {S_EXEC, S_MEM, S_WB};
    en_im      = r_state == S_FETCH;
    alu_src    = w_alu && w_alu_src;
    alu_ctrl   = w_alu ? w_alu_ctrl : 3'b000;
    mem_read   = w_lw && (r_state inside {S_MEM, S_WB});
    mem_write  = w_sw && r_state == S_MEM;
    en_rw      = r_state == S_WB;
    mem_to_reg = en_rw && !w_lw;
    busy       = !(r_state inside {S_IDLE, S_HALTED});
    halted     = r_state == S_HALTED;
    illegal    = r_state == S_DECODE && w_illegal;
  end
  assign pc  = r_pc;
  assign imm = r_ir[15:0];
  assign rn1 = r_ir[27:24];
  assign rn2 = r_ir[23:20];
  assign wn  = r_ir[19:16];
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-scenario checks of the multi-cycle controller
module tb_multicycle_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, zero = 0;
  logic [31:0] instr = '0;
  logic [4:0]  pc;
  logic        en_im, alu_src, mem_read, mem_write, mem_to_reg, en_rw, busy, halted, illegal;
  logic [15:0] imm;
  logic [3:0]  rn1, rn2, wn;
  logic [2:0]  alu_ctrl;
  logic [11:0] ctl;
  logic [44:0] all_o;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.PC_W(5), .RST_PC(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .zero(zero),
    .pc(pc), .en_im(en_im), .imm(imm), .rn1(rn1), .rn2(rn2), .wn(wn),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .en_rw(en_rw), .busy(busy), .halted(halted), .illegal(illegal)
  );
  // ctl = {en_im, alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg, en_rw, busy, halted, illegal}
  assign ctl   = {en_im, alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg, en_rw, busy, halted, illegal};
  assign all_o = {pc, imm, rn1, rn2, wn, ctl};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    tick();
    tick();
    total++; if (all_o !== 45'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_o); end
    rst_n = 1;
    tick();
    total++; if (ctl !== 12'd0) begin bad++; $display("FAIL idle_no_start ctl=%b exp=0", ctl); end
  endtask
  task automatic test_add;
    start = 1;
    tick();
    start = 0;
    instr = 32'h2123_0000;
    total++; if ({pc, ctl} !== {5'd0, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL add_fetch pc/ctl=%h exp=%h", {pc, ctl}, {5'd0, 12'b1_0_000_0000_100}); end
    tick();
    total++; if ({rn1, rn2, wn, pc} !== {4'd1, 4'd2, 4'd3, 5'd4}) begin bad++; $display("FAIL add_decode rn/pc=%h exp=%h", {rn1, rn2, wn, pc}, {4'd1, 4'd2, 4'd3, 5'd4}); end
    total++; if (ctl !== 12'b0_0_000_0000_100) begin bad++; $display("FAIL add_decode_ctl got=%b exp=%b", ctl, 12'b0_0_000_0000_100); end
    tick();
    total++; if (ctl !== 12'b0_0_010_0000_100) begin bad++; $display("FAIL add_exec got=%b exp=%b", ctl, 12'b0_0_010_0000_100); end
    tick();
    total++; if ({wn, ctl} !== {4'd3, 12'b0_0_010_0011_100}) begin bad++; $display("FAIL add_wb got=%h exp=%h", {wn, ctl}, {4'd3, 12'b0_0_010_0011_100}); end
    tick();
    total++; if ({pc, ctl} !== {5'd4, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL add_refetch got=%h exp=%h", {pc, ctl}, {5'd4, 12'b1_0_000_0000_100}); end
  endtask
  task automatic test_lw;
    logic seen_mw = 0;
    instr = 32'h9104_0014;
    tick();
    seen_mw |= mem_write;
    total++; if ({rn1, wn, imm} !== {4'd1, 4'd4, 16'h0014}) begin bad++; $display("FAIL lw_decode got=%h exp=%h", {rn1, wn, imm}, {4'd1, 4'd4, 16'h0014}); end
    tick();
    seen_mw |= mem_write;
    total++; if (ctl !== 12'b0_1_010_0000_100) begin bad++; $display("FAIL lw_exec got=%b exp=%b", ctl, 12'b0_1_010_0000_100); end
    tick();
    seen_mw |= mem_write;
    total++; if (ctl !== 12'b0_1_010_1000_100) begin bad++; $display("FAIL lw_mem got=%b exp=%b", ctl, 12'b0_1_010_1000_100); end
    tick();
    seen_mw |= mem_write;
    total++; if ({wn, ctl} !== {4'd4, 12'b0_1_010_1001_100}) begin bad++; $display("FAIL lw_wb got=%h exp=%h", {wn, ctl}, {4'd4, 12'b0_1_010_1001_100}); end
    tick();
    total++; if ({pc, ctl} !== {5'd8, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL lw_refetch got=%h exp=%h", {pc, ctl}, {5'd8, 12'b1_0_000_0000_100}); end
    total++; if (seen_mw !== 1'b0) begin bad++; $display("FAIL lw_no_mem_write got=%b exp=0", seen_mw); end
  endtask
  task automatic test_beq(input logic [31:0] ins, input logic z, input logic [4:0] exp_pc);
    instr = ins;
    zero  = z;
    tick();
    tick();
    total++; if (ctl !== 12'b0_0_110_0000_100) begin bad++; $display("FAIL beq_exec got=%b exp=%b", ctl, 12'b0_0_110_0000_100); end
    tick();
    zero = 0;
    total++; if ({pc, ctl} !== {exp_pc, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL beq_target got=%h exp=%h", {pc, ctl}, {exp_pc, 12'b1_0_000_0000_100}); end
  endtask
  task automatic test_sw;
    instr = 32'hA120_0008;
    tick();
    tick();
    total++; if (ctl !== 12'b0_1_010_0000_100) begin bad++; $display("FAIL sw_exec got=%b exp=%b", ctl, 12'b0_1_010_0000_100); end
    tick();
    total++; if (ctl !== 12'b0_1_010_0100_100) begin bad++; $display("FAIL sw_mem got=%b exp=%b", ctl, 12'b0_1_010_0100_100); end
    tick();
    total++; if ({pc, ctl} !== {5'd24, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL sw_refetch got=%h exp=%h", {pc, ctl}, {5'd24, 12'b1_0_000_0000_100}); end
  endtask
  task automatic test_illegal(input logic [4:0] exp_pc);
    instr = 32'h5000_0000;
    tick();
    total++; if (ctl !== 12'b0_0_000_0000_101) begin bad++; $display("FAIL illegal_decode got=%b exp=%b", ctl, 12'b0_0_000_0000_101); end
    tick();
    total++; if ({pc, ctl} !== {exp_pc, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL illegal_next got=%h exp=%h", {pc, ctl}, {exp_pc, 12'b1_0_000_0000_100}); end
  endtask
  task automatic test_halt;
    instr = 32'hF000_0000;
    tick();
    tick();
    total++; if ({pc, ctl} !== {5'd16, 12'b0_0_000_0000_010}) begin bad++; $display("FAIL halt_state got=%h exp=%h", {pc, ctl}, {5'd16, 12'b0_0_000_0000_010}); end
    start = 1;
    tick();
    tick();
    start = 0;
    tick();
    total++; if ({pc, ctl} !== {5'd16, 12'b0_0_000_0000_010}) begin bad++; $display("FAIL halt_ignores_start got=%h exp=%h", {pc, ctl}, {5'd16, 12'b0_0_000_0000_010}); end
  endtask
  task automatic test_reset_mid;
    rst_n = 0;
    tick();
    rst_n = 1;
    start = 1;
    tick();
    start = 0;
    instr = 32'hA120_0008;
    total++; if ({pc, ctl} !== {5'd0, 12'b1_0_000_0000_100}) begin bad++; $display("FAIL rst_restart got=%h exp=%h", {pc, ctl}, {5'd0, 12'b1_0_000_0000_100}); end
    tick();
    tick();
    tick();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rst_pre_mem got=%b exp=1", mem_write); end
    rst_n = 0;
    tick();
    total++; if (all_o !== 45'd0) begin bad++; $display("FAIL rst_mid_mem got=%h exp=0", all_o); end
    rst_n = 1;
    tick();
    total++; if (all_o !== 45'd0) begin bad++; $display("FAIL rst_after_release got=%h exp=0", all_o); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq(32'hB120_0002, 1'b1, 5'd20);
    test_sw();
    test_illegal(5'd28);
    test_beq(32'hB000_0001, 1'b1, 5'd4);
    test_illegal(5'd8);
    test_beq(32'hB120_0002, 1'b0, 5'd12);
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit that drives the existing single-cycle datapath pieces: instruction memory, register file, ALU, ALU source mux, data memory and writeback mux. It owns the PC and instruction register and sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. Its outputs connect directly to the enables, selects and register numbers of those blocks.

Parameters:
PC_W, 5, PC width; byte address into instruction memory; PC steps by 4 and wraps mod 32.
RST_PC, 0, PC value after reset.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  synchronous active-low reset.
start  in  1  leave IDLE and begin fetching; ignored in all other states.
instr  in  32  instruction memory data; valid while en_im=1.
zero  in  1  ALU zero flag; sampled in EXEC for BEQ.
pc  out  PC_W  current fetch address to instruction memory.
en_im  out  1  instruction memory enable.
imm  out  16  IR[15:0], goes to the sign extender.
rn1, rn2, wn  out  4 each  register read/write numbers: IR[27:24], IR[23:20], IR[19:16].
alu_src  out  1  1 = extended immediate, 0 = rd2.
alu_ctrl  out  3  ALU operation code.
mem_read, mem_write  out  1 each  data memory controls.
mem_to_reg  out  1  writeback select: 1 = ALU result, 0 = memory data.
en_rw  out  1  register file write enable; the file writes on negedge.
busy  out  1  high in any state except IDLE and HALTED.
halted  out  1  high in HALTED.
illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Instruction format: [31:28] opcode, [27:24] rs, [23:20] rt, [19:16] rd, [15:0] imm.
- Opcode map:
  - R-type: 0x0 AND, 0x1 OR, 0x2 ADD, 0x3 NOR, 0x6 SUB, 0x7 SLT. alu_ctrl = opcode[2:0]; result goes to rd.
  - 0x8 ADDI: rd = rs + sext(imm).
  - 0x9 LW: rd = mem[rs + sext(imm)].
  - 0xA SW: mem[rs + sext(imm)] = rt.
  - 0xB BEQ: ALU does SUB of rs and rt.
  - 0xF HALT.
  - Any other opcode is illegal.
- Reset (rst_n=0 at posedge): state IDLE, pc=RST_PC, IR=0, and every output 0. This applies mid-instruction: mem_write and en_rw drop at that edge and no later commit occurs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED. All outputs are decoded from the registered state and IR only, so they are glitch-free at negedge.
- IDLE: goes to FETCH when start=1.
- FETCH: en_im=1. At the edge, IR <= instr and pc <= pc+4 (mod 32). Next state is DECODE.
- DECODE: rn1, rn2 and wn valid from IR.
  - HALT goes to HALTED.
  - Illegal opcode: illegal=1 for this cycle, then FETCH (treated as a NOP).
  - All other opcodes go to EXEC.
- EXEC:
  - alu_src = 1 for ADDI, LW and SW; 0 otherwise.
  - alu_ctrl = 010 for ADDI, LW and SW; 110 for BEQ; opcode[2:0] for R-type.
  - BEQ: if zero=1, pc <= pc + {imm,2'b00} truncated to PC_W. Then FETCH.
  - LW and SW go to MEM. R-type and ADDI go to WB.
- MEM: alu_src and alu_ctrl held.
  - SW: mem_write=1 for exactly this cycle, then FETCH.
  - LW: mem_read=1, then WB.
- WB: en_rw=1 for exactly this cycle, with alu_src, alu_ctrl and wn held.
  - mem_to_reg = 0 for LW (mem_read stays 1 through WB); 1 otherwise.
  - Next state is FETCH.
- Latency in cycles: R-type and ADDI 4, LW 5, SW 4, BEQ 3, illegal 2.
- HALTED: halted=1 and all enables 0. Only reset exits this state; start is ignored.
- pc wraps from 28 to 0. A branch target wraps mod 32.
- mem_read and mem_write are never both 1. en_rw is never 1 outside WB.

Decomposition:
- Package multicycle_pkg: opcode constants, ALU control constants (AND=000, OR=001, ADD=010, NOR=011, SUB=110, SLT=111) and the state enum.
- Sub-module ctrl_decode: combinational opcode to instruction class (rtype, addi, lw, sw, beq, halt, illegal) plus the EXEC alu_ctrl and alu_src values.

Test Plan:
- Reset, then start; instr 32'h2123_0000 (ADD r3=r1+r2) -> en_im=1 with pc=0, then DECODE rn1=1 rn2=2 wn=3, then EXEC alu_ctrl=010 alu_src=0, then WB en_rw=1 mem_to_reg=1; pc=4 and 4 cycles total.
- LW 32'h9104_0014 -> alu_src=1, alu_ctrl=010, mem_read=1 in MEM and WB, WB mem_to_reg=0 en_rw=1 wn=4; 5 cycles, mem_write never 1.
- SW 32'hA120_0008 -> mem_write=1 for exactly one cycle in MEM; en_rw stays 0; back to FETCH with pc=+4.
- BEQ 32'hB120_0002 at pc=8 with zero=1 -> pc=20; same instruction with zero=0 -> pc=12. BEQ at pc=28 with imm=1 and zero=1 -> pc=4 (wrap).
- Opcode 0x5 -> illegal pulses 1 cycle in DECODE, no enables asserted, next fetch at pc+4. HALT 32'hF000_0000 -> halted=1 and busy=0; start pulses ignored.
- rst_n=0 during the MEM cycle of an SW -> mem_write=0 from that edge, state IDLE, pc=0, and all outputs 0 on the next cycle.
